bundle_counter_array: RTL and testbench
=======================================

Name: bundle_counter_array

Overview:
- D-lane bipolar bundling accumulator for the HPU datapath. Each lane keeps a signed W-bit counter: +1 for an input bit of 0, -1 for an input bit of 1.
- At the end of a bundle it emits the per-lane sign vector (majority hypervector), applies a configurable tie-break and clears itself for the next bundle without a bubble.
- Sits between the binding/permutation stage and the result write-back.

Parameters:
- D, 32, number of lanes (hypervector bits processed per cycle), >=1
- W, 16, signed counter width per lane, >=2
- CW, 16, width of the bundle vector-count output
- TIE_MODE, 0, 0: tie outputs 0; 1: tie outputs 1; 2: tie outputs that lane's bit of the final vector

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  abort the current bundle; zero all counters
- in_valid  in  1  in_bits/in_last valid this cycle (no backpressure; always accepted)
- in_bits  in  D  input hypervector bits
- in_last  in  1  in_bits is the final vector of the bundle (qualified by in_valid)
- out_valid  out  1  one-cycle pulse; out_bits/out_count/out_sat valid
- out_bits  out  D  majority vector: 1 = lane counter negative
- out_count  out  CW  number of vectors accumulated in the emitted bundle (saturates at 2^CW-1)
- out_sat  out  1  some lane saturated during the emitted bundle

Behaviour:
- Reset (rst=1 at a clk edge): all lane counters 0, vector count 0, sticky sat 0, out_valid 0, out_bits 0, out_count 0, out_sat 0. rst overrides every other input.
- Lane update on an accepted vector (in_valid=1): next = base + (bit ? -1 : +1).
  - base = 0 if clear=1 or if the previous accepted vector had in_last=1; otherwise base = current counter.
- Saturation: each counter clamps to [-(2^(W-1)-1), +(2^(W-1)-1)]. The value -2^(W-1) is never reached.
  - An update that would exceed a limit holds the limit and sets the sticky sat flag for that bundle.
- Vector count: +1 per accepted vector, saturating at 2^CW-1. It uses the same base rule as the lane counters.
- Emission when in_valid=1 and in_last=1: from the post-update lane values, at the next edge
  - out_valid=1 for exactly one cycle;
  - out_bits[i] = 1 if counter<0, 0 if counter>0;
  - counter==0 resolves per TIE_MODE (mode 2 uses in_bits[i] of this final vector);
  - out_count = count including this vector;
  - out_sat = sticky sat including this update.
  - Latency: 1 cycle from the in_last beat.
- After emission, the internal counters are logically zero for the next bundle. Back-to-back bundles are allowed (in_last on consecutive cycles gives out_valid on consecutive cycles).
  - Single-vector bundle (in_valid+in_last on the first beat) is legal: out_bits = in_bits, out_count = 1.
- out_bits/out_count/out_sat hold their last emitted values while out_valid=0.
- clear without in_valid: counters, count and sat become 0 next edge; nothing is emitted.
- clear with in_valid: the vector starts a fresh bundle (counters ±1, count 1). If in_last is also high, the result is emitted as a one-vector bundle.
- in_valid=0: no state change except clear/rst. in_last and in_bits are ignored when in_valid=0.
- A bundle still open at reset is discarded with no emission.

Test Plan:
- D=4, W=4, TIE_MODE=0: vectors 0000, 0011, 0101(last) -> out_valid 1 cycle after last beat, out_bits=0001, out_count=3, out_sat=0.
- Tie, D=2: vectors 01, 10(last) -> counters 0,0. Required out_bits: TIE_MODE=0 gives 00; TIE_MODE=1 gives 11; TIE_MODE=2 gives 10.
- Saturation, W=4 (limit ±7), D=1: nine 0-vectors, last flagged -> out_bits=0, out_sat=1, out_count=9.
  - Follow-up bundle of eight 1-vectors -> counter reaches -7, out_bits=1, out_sat=1. Proves the new bundle started from 0 and sat re-armed.
- Back-to-back: in_last asserted on two consecutive beats with bits 1 then 0 (D=1) -> out_valid high 2 consecutive cycles, out_bits 1 then 0, out_count 1 each.
- Clear: 5 vectors of 1 without last, then clear+in_valid with bit 0 and in_last -> out_bits=0, out_count=1.
  - Separately, clear alone then a last vector of 1 -> out_bits=1, out_count=1.
- Reset mid-bundle: 3 vectors accumulated, rst=1 one cycle, then 1-vector bundle with bit 0 -> all outputs 0 during reset, then out_bits=0, out_count=1, out_sat=0.

Source files
------------

// File: rtl/bundle_counter_array.sv
// Bipolar bundling accumulator: one saturating signed counter per lane,
// majority (sign) vector emitted one cycle after the last beat of a bundle.
module bundle_counter_array #(
  parameter int unsigned D        = 32,
  parameter int unsigned W        = 16,
  parameter int unsigned CW       = 16,
  parameter int unsigned TIE_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [D-1:0]  in_bits,
  input  logic          in_last,
  output logic          out_valid,
  output logic [D-1:0]  out_bits,
  output logic [CW-1:0] out_count,
  output logic          out_sat
);

  // Symmetric clamp limits; the most negative code is never used.
  localparam logic [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinVal = (~MaxVal) + {{(W-1){1'b0}}, 1'b1};

  logic [D-1:0][W-1:0] cnt_q, cnt_d, base, upd;
  logic [CW-1:0]       vcnt_q, vcnt_d, vcnt_base, vcnt_upd;
  logic                sat_q, sat_d, sat_hit, sat_upd;
  logic                out_valid_q, out_valid_d;
  logic [D-1:0]        out_bits_q, out_bits_d;
  logic [CW-1:0]       out_count_q, out_count_d;
  logic                out_sat_q, out_sat_d;

  // Post-update lane values, count and sticky flag for the accepted vector.
  // Counters are zeroed at emission, so only clear selects a zero base here.
  always_comb begin
    base    = '0;
    upd     = '0;
    sat_hit = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      base[i] = clear ? '0 : cnt_q[i];
      if (in_bits[i]) begin
        if (base[i] == MinVal) begin
          upd[i]  = MinVal;
          sat_hit = 1'b1;
        end else begin
          upd[i] = base[i] - {{(W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (base[i] == MaxVal) begin
          upd[i]  = MaxVal;
          sat_hit = 1'b1;
        end else begin
          upd[i] = base[i] + {{(W-1){1'b0}}, 1'b1};
        end
      end
    end
    vcnt_base = clear ? '0 : vcnt_q;
    vcnt_upd  = (vcnt_base == {CW{1'b1}}) ? vcnt_base : vcnt_base + {{(CW-1){1'b0}}, 1'b1};
    sat_upd   = (clear ? 1'b0 : sat_q) | sat_hit;
  end

  // Next state: accumulate, emit on last beat (and restart from zero), or clear.
  always_comb begin
    cnt_d       = cnt_q;
    vcnt_d      = vcnt_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    out_bits_d  = out_bits_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (in_valid) begin
      if (in_last) begin
        cnt_d       = '0;
        vcnt_d      = '0;
        sat_d       = 1'b0;
        out_valid_d = 1'b1;
        out_count_d = vcnt_upd;
        out_sat_d   = sat_upd;
        for (int i = 0; i < int'(D); i++) begin
          if (upd[i] == '0) begin
            case (TIE_MODE)
              0:       out_bits_d[i] = 1'b0;
              1:       out_bits_d[i] = 1'b1;
              default: out_bits_d[i] = in_bits[i];
            endcase
          end else begin
            out_bits_d[i] = upd[i][W-1];
          end
        end
      end else begin
        cnt_d  = upd;
        vcnt_d = vcnt_upd;
        sat_d  = sat_upd;
      end
    end else if (clear) begin
      cnt_d  = '0;
      vcnt_d = '0;
      sat_d  = 1'b0;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      vcnt_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      vcnt_q      <= vcnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_bundle_counter_array.sv
// Bench for bundle_counter_array: three instances (one per tie mode) share stimulus;
// a behavioural model of the bundling rules predicts every output after every edge.
module tb_bundle_counter_array;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int CW = 4;
  localparam int Lim  = (1 << (W - 1)) - 1;
  localparam int CMax = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_last;
  logic [D-1:0] in_bits;
  logic          ov0, ov1, ov2;
  logic [D-1:0]  ob0, ob1, ob2;
  logic [CW-1:0] oc0, oc1, oc2;
  logic          os0, os1, os2;

  always #5 clk = ~clk;

  bundle_counter_array #(.D(D), .W(W), .CW(CW), .TIE_MODE(0)) u_t0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bits(in_bits),
    .in_last(in_last), .out_valid(ov0), .out_bits(ob0), .out_count(oc0), .out_sat(os0));
  bundle_counter_array #(.D(D), .W(W), .CW(CW), .TIE_MODE(1)) u_t1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bits(in_bits),
    .in_last(in_last), .out_valid(ov1), .out_bits(ob1), .out_count(oc1), .out_sat(os1));
  bundle_counter_array #(.D(D), .W(W), .CW(CW), .TIE_MODE(2)) u_t2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bits(in_bits),
    .in_last(in_last), .out_valid(ov2), .out_bits(ob2), .out_count(oc2), .out_sat(os2));

  int total = 0;
  int fails = 0;

  // Reference model state.
  int acc [D];
  int m_cnt;
  bit m_sat;
  bit m_fresh;
  bit e_valid;
  bit [D-1:0] e_bits [3];
  int e_count;
  bit e_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < D; i++) acc[i] = 0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic step(input string tag, input bit r, input bit c, input bit v,
                      input bit l, input logic [D-1:0] b);
    rst = r; clear = c; in_valid = v; in_last = l; in_bits = b;
    if (r) begin
      model_zero();
      m_fresh = 1'b0;
      e_valid = 1'b0;
      for (int m = 0; m < 3; m++) e_bits[m] = '0;
      e_count = 0;
      e_sat   = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (v) begin
        if (c || m_fresh) model_zero();
        for (int i = 0; i < D; i++) begin
          acc[i] += b[i] ? -1 : 1;
          if (acc[i] > Lim)  begin acc[i] = Lim;  m_sat = 1'b1; end
          if (acc[i] < -Lim) begin acc[i] = -Lim; m_sat = 1'b1; end
        end
        if (m_cnt < CMax) m_cnt++;
        m_fresh = l;
        if (l) begin
          e_valid = 1'b1;
          e_count = m_cnt;
          e_sat   = m_sat;
          for (int i = 0; i < D; i++) begin
            e_bits[0][i] = (acc[i] < 0) ? 1'b1 : 1'b0;
            e_bits[1][i] = (acc[i] <= 0) ? 1'b1 : 1'b0;
            e_bits[2][i] = (acc[i] < 0) ? 1'b1 : ((acc[i] > 0) ? 1'b0 : b[i]);
          end
        end
      end else if (c) begin
        model_zero();
        m_fresh = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid0"}, 32'(ov0), 32'(e_valid));
    chk({tag, ".valid1"}, 32'(ov1), 32'(e_valid));
    chk({tag, ".valid2"}, 32'(ov2), 32'(e_valid));
    chk({tag, ".bits_t0"}, 32'(ob0), 32'(e_bits[0]));
    chk({tag, ".bits_t1"}, 32'(ob1), 32'(e_bits[1]));
    chk({tag, ".bits_t2"}, 32'(ob2), 32'(e_bits[2]));
    chk({tag, ".count"}, 32'(oc0), 32'(e_count));
    chk({tag, ".count2"}, 32'(oc2), 32'(e_count));
    chk({tag, ".sat"}, 32'(os0), 32'(e_sat));
    chk({tag, ".sat2"}, 32'(os2), 32'(e_sat));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bits = '0;
    m_fresh = 1'b0;
    model_zero();
    step("reset", 1, 0, 0, 0, 4'b0000);
    step("idle", 0, 0, 0, 0, 4'b1111);

    // Basic majority.
    step("basic_a", 0, 0, 1, 0, 4'b0000);
    step("basic_b", 0, 0, 1, 0, 4'b0011);
    step("basic_c", 0, 0, 1, 1, 4'b0101);
    chk("basic.bits_literal", 32'(ob0), 32'h1);
    chk("basic.count_literal", 32'(oc0), 32'd3);
    step("hold", 0, 0, 0, 1, 4'b1010);

    // Ties in lanes 0 and 1.
    step("tie_a", 0, 0, 1, 0, 4'b0001);
    step("tie_b", 0, 0, 1, 1, 4'b0010);
    chk("tie.t2_literal", 32'(ob2), 32'h2);

    // Saturation, then a bundle driving the other limit.
    for (int k = 0; k < 9; k++) step("satp", 0, 0, 1, k == 8, 4'b0000);
    chk("satp.sat_literal", 32'(os0), 32'd1);
    chk("satp.count_literal", 32'(oc0), 32'd9);
    for (int k = 0; k < 8; k++) step("satn", 0, 0, 1, k == 7, 4'b1111);
    chk("satn.bits_literal", 32'(ob0), 32'hF);
    // Seven steps reach the limit without saturating.
    for (int k = 0; k < 7; k++) step("nosat", 0, 0, 1, k == 6, 4'b1111);
    chk("nosat.sat_literal", 32'(os0), 32'd0);

    // Back-to-back single-vector bundles.
    step("b2b_a", 0, 0, 1, 1, 4'b0001);
    step("b2b_b", 0, 0, 1, 1, 4'b0000);
    step("b2b_idle", 0, 0, 0, 0, 4'b0000);

    // Clear with and without a vector.
    for (int k = 0; k < 5; k++) step("clr_acc", 0, 0, 1, 0, 4'b1111);
    step("clr_v", 0, 1, 1, 1, 4'b0000);
    for (int k = 0; k < 3; k++) step("clr_acc2", 0, 0, 1, 0, 4'b0000);
    step("clr_only", 0, 1, 0, 0, 4'b0000);
    step("clr_last", 0, 0, 1, 1, 4'b1111);

    // Reset mid-bundle.
    for (int k = 0; k < 3; k++) step("rst_acc", 0, 0, 1, 0, 4'b1111);
    step("rst_mid", 1, 0, 1, 1, 4'b1111);
    step("rst_after", 0, 0, 1, 1, 4'b0000);

    // Vector-count saturation.
    for (int k = 0; k < 20; k++) step("csat", 0, 0, 1, k == 19, 4'($urandom));
    chk("csat.count_literal", 32'(oc0), 32'(CMax));

    // Random traffic: short bundles, then long bundles.
    for (int k = 0; k < 300; k++)
      step("rnd_s", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 4'($urandom));
    for (int k = 0; k < 300; k++)
      step("rnd_l", 1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 29) == 0), 4'($urandom_range(0, 3) == 0 ? 4'hF : 4'($urandom)));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
